mp_addsub_ctrl: RTL

Multi-precision add/subtract sequencer built around one 32-bit carry-lookahead slice pair.
- Accepts a WORDS×32-bit operand pair with a single-request handshake.
- Streams the operands through the shared 32-bit datapath one word per cycle, least-significant word first, chaining carry/borrow in a register.
- Returns the full-width result, carry and signed overflow on a valid/ready output.
- Sits between the ALU issue logic and the CLA datapath, for operands wider than 32 bits.

---
 rtl/mp_addsub_ctrl.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/mp_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// mp_addsub_ctrl
//
// Multi-precision add/subtract sequencer. A WORDS x 32-bit operand pair is
// accepted in one handshake, then streamed least-significant word first
// through a single 32-bit datapath built from two 16-bit carry-lookahead
// slices. The inter-word carry/borrow is chained through a register, so the
// full-width result appears WORDS cycles after acceptance.
//
// Ports:
//   clk        single clock, rising-edge
//   rst        synchronous reset, active-high
//   in_valid   request valid
//   in_ready   controller can accept a request (IDLE only)
//   sub        0 = A+B, 1 = A-B (two's complement)
//   op_a/op_b  operands, word 0 = bits [31:0]
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   result     A+B or A-B modulo 2^(32*WORDS)
//   carry_out  final carry; for sub, 1 = no borrow (A >= B unsigned)
//   overflow   signed overflow of the full-width operation
//   busy       high in RUN or DONE
// ---------------------------------------------------------------------------
module mp_addsub_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  sub,
    input  logic [32*WORDS-1:0]   op_a,
    input  logic [32*WORDS-1:0]   op_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*WORDS-1:0]   result,
    output logic                  carry_out,
    output logic                  overflow,
    output logic                  busy
);

    localparam int W  = 32 * WORDS;
    localparam int IW = $clog2(WORDS) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // 16-bit carry-lookahead adder: four 4-bit groups with group
    // generate/propagate, group carries resolved by lookahead, and bit
    // carries inside each group expanded from the group carry-in.
    // Returns {carry_out, sum}.
    function automatic logic [16:0] cla16(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic        cin);
        logic [15:0] g;
        logic [15:0] p;
        logic [15:0] c;
        logic [3:0]  gg;
        logic [3:0]  gp;
        logic [4:0]  gc;
        g = a & b;
        p = a ^ b;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        gc[0] = cin;
        for (int k = 0; k < 4; k++) begin
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
        return {gc[4], p ^ c};
    endfunction

    // State and registered outputs
    state_t          state_q,     state_d;
    logic [W-1:0]    a_q,         a_d;
    logic [W-1:0]    b_q,         b_d;
    logic            sub_q,       sub_d;
    logic            cy_q,        cy_d;
    logic [IW-1:0]   idx_q,       idx_d;
    logic [W-1:0]    result_q,    result_d;
    logic            carry_out_q, carry_out_d;
    logic            overflow_q,  overflow_d;
    logic            in_ready_q,  in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q,      busy_d;

    // Datapath signals for the word currently being processed
    logic [31:0]     a_word;
    logic [31:0]     b_word;
    logic [31:0]     b_eff;
    logic [16:0]     lo_slice;
    logic [16:0]     hi_slice;
    logic [31:0]     sum_word;
    logic            word_carry;
    logic            last_word;

    // Word select from the latched operands (decoded mux, so no index can
    // ever address outside the operand).
    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx_q == IW'(w)) begin
                a_word = a_q[32*w +: 32];
                b_word = b_q[32*w +: 32];
            end
        end
    end

    // Subtraction is A + ~B + 1; the +1 comes from the carry register,
    // which is preset to sub on acceptance.
    assign b_eff      = b_word ^ {32{sub_q}};
    assign lo_slice   = cla16(a_word[15:0],  b_eff[15:0],  cy_q);
    assign hi_slice   = cla16(a_word[31:16], b_eff[31:16], lo_slice[16]);
    assign sum_word   = {hi_slice[15:0], lo_slice[15:0]};
    assign word_carry = hi_slice[16];
    assign last_word  = (idx_q == IW'(WORDS - 1));

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sub_d       = sub_q;
        cy_d        = cy_q;
        idx_d       = idx_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = op_a;
                    b_d        = op_b;
                    sub_d      = sub;
                    cy_d       = sub;
                    idx_d      = '0;
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            RUN: begin
                for (int w = 0; w < WORDS; w++) begin
                    if (idx_q == IW'(w)) begin
                        result_d[32*w +: 32] = sum_word;
                    end
                end
                cy_d  = word_carry;
                idx_d = idx_q + IW'(1);
                if (last_word) begin
                    carry_out_d = word_carry;
                    overflow_d  = (a_word[31] == b_eff[31]) &&
                                  (sum_word[31] != a_word[31]);
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                // No accept in the handoff cycle: in_ready only rises
                // once we are back in IDLE.
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            cy_q        <= 1'b0;
            idx_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            cy_q        <= cy_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign busy      = busy_q;

endmodule
